oled_spi_tx: RTL and testbench

OLED_SPI_TX -- requirements
Module: oled_spi_tx

---
 rtl/oled_spi_tx.sv | 155 +++++++++++++++
 tb/tb_oled_spi_tx.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_spi_tx.sv
// Write-only SPI master for an SSD13xx-style OLED PMOD: a small {DC, byte} FIFO
// feeding a mode-3 serialiser with chip-select framing and fully registered pins.
module oled_spi_tx #(
  parameter int WIDTH        = 8,
  parameter int SCLK_DIVIDER = 20,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic [WIDTH-1:0] i_DATA,
  input  logic             i_DC,
  input  logic             i_VALID,
  output logic             o_READY,
  output logic             o_IDLE,
  output logic             o_CS,
  output logic             o_MOSI,
  output logic             o_SCK,
  output logic             o_DC
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DIV_W = (SCLK_DIVIDER > 1) ? $clog2(SCLK_DIVIDER) : 1;
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_HOLD,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               dc_q, dc_d;
  logic               cs_q, cs_d;
  logic               sck_q, sck_d;
  logic               mosi_q, mosi_d;
  logic               ready_q, ready_d;
  logic               idle_q, idle_d;
  logic               push, pop, last, frame_active;

  // Each entry is {DC, byte}.
  logic [WIDTH:0]     mem_q [FIFO_DEPTH];

  // NOTE: FIFO storage carries no reset; count and pointers alone decide which
  // entries are valid, so clearing the array would only cost routing.
  always_ff @(posedge i_CLK) begin
    if (push) mem_q[wr_ptr_q] <= {i_DC, i_DATA};
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    data_d   = data_q;
    dc_d     = dc_q;
    last     = (div_q == DIV_W'(SCLK_DIVIDER - 1));
    push     = i_VALID && (count_q < CNT_W'(FIFO_DEPTH));
    pop      = (state_q == S_IDLE) && (count_q != '0);

    if (state_q != S_IDLE) div_d = last ? '0 : div_q + DIV_W'(1);

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = S_SETUP;
          div_d   = '0;
          bit_d   = BIT_W'(WIDTH - 1);
          data_d  = mem_q[rd_ptr_q][WIDTH-1:0];
          dc_d    = mem_q[rd_ptr_q][WIDTH];
        end
      end
      S_SETUP:    if (last) state_d = S_SHIFT_LO;
      S_SHIFT_LO: if (last) state_d = S_SHIFT_HI;
      S_SHIFT_HI: begin
        if (last) begin
          if (bit_q != '0) begin
            bit_d   = bit_q - BIT_W'(1);
            state_d = S_SHIFT_LO;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD:     if (last) state_d = S_GAP;
      S_GAP:      if (last) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    // Pins are computed from the next state so the registered outputs line up
    // with the state they belong to, with no extra cycle of lag.
    frame_active = (state_d == S_SETUP) || (state_d == S_SHIFT_LO) ||
                   (state_d == S_SHIFT_HI) || (state_d == S_HOLD);
    cs_d    = !frame_active;
    sck_d   = (state_d != S_SHIFT_LO);
    mosi_d  = frame_active ? data_d[bit_d] : 1'b0;
    ready_d = (count_d < CNT_W'(FIFO_DEPTH));
    idle_d  = (state_d == S_IDLE) && (count_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      data_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dc_q     <= 1'b0;
      cs_q     <= 1'b1;
      sck_q    <= 1'b1;
      mosi_q   <= 1'b0;
      ready_q  <= 1'b1;
      idle_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dc_q     <= dc_d;
      cs_q     <= cs_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
      ready_q  <= ready_d;
      idle_q   <= idle_d;
    end
  end

  assign o_READY = ready_q;
  assign o_IDLE  = idle_q;
  assign o_CS    = cs_q;
  assign o_SCK   = sck_q;
  assign o_MOSI  = mosi_q;
  assign o_DC    = dc_q;

endmodule

// File: tb/tb_oled_spi_tx.sv
// Directed bench for oled_spi_tx (WIDTH=8, H=2, depth 4): a pin monitor decodes
// frames on the bus and the test compares them with hand-computed expectations.
module tb_oled_spi_tx;

  localparam int W = 8;
  localparam int H = 2;
  localparam int D = 4;
  localparam int LOW_CYC   = (2 * W + 2) * H;      // 36
  localparam int PITCH_CYC = (2 * W + 3) * H + 1;  // 39

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       dc;
  logic       valid;
  logic       o_ready, o_idle, o_cs, o_mosi, o_sck, o_dc;

  oled_spi_tx #(.WIDTH(W), .SCLK_DIVIDER(H), .FIFO_DEPTH(D)) dut (
    .i_CLK   (clk),
    .i_RST   (rst),
    .i_DATA  (data),
    .i_DC    (dc),
    .i_VALID (valid),
    .o_READY (o_ready),
    .o_IDLE  (o_idle),
    .o_CS    (o_cs),
    .o_MOSI  (o_mosi),
    .o_SCK   (o_sck),
    .o_DC    (o_dc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus monitor: sampled on the falling clock edge, away from output updates.
  typedef struct {
    logic [7:0] byte_v;
    logic       dc;
    int         rises;
    int         low;
    int         fall;
  } frame_t;

  frame_t     frames[$];
  logic       prev_cs = 1'b1, prev_sck = 1'b1, prev_dc = 1'b0;
  logic       in_frame = 1'b0, frame_dc = 1'b0;
  logic [7:0] shreg = '0;
  int         cur_rises = 0, fall_cyc = 0;
  int         dc_bad = 0, idle_sck_bad = 0, last_dc_change = -1;

  always @(negedge clk) begin
    if (rst) begin
      in_frame  = 1'b0;
      cur_rises = 0;
      prev_cs   = 1'b1;
      prev_sck  = 1'b1;
      prev_dc   = 1'b0;
    end else begin
      if (o_dc !== prev_dc) begin
        last_dc_change = cyc;
        if (!prev_cs) dc_bad++;
      end
      if (o_cs && !o_sck) idle_sck_bad++;
      if (prev_cs && !o_cs) begin
        in_frame  = 1'b1;
        fall_cyc  = cyc;
        cur_rises = 0;
        shreg     = '0;
        frame_dc  = o_dc;
      end else if (!o_cs && !prev_sck && o_sck) begin
        shreg = {shreg[6:0], o_mosi};
        cur_rises++;
      end
      if (!prev_cs && o_cs && in_frame) begin
        frames.push_back('{byte_v: shreg, dc: frame_dc, rises: cur_rises,
                           low: cyc - fall_cyc, fall: fall_cyc});
        in_frame = 1'b0;
      end
      prev_cs  = o_cs;
      prev_sck = o_sck;
      prev_dc  = o_dc;
    end
  end

  // Bench actions happen just after the falling edge, once the monitor has run.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic c);
    data  = d;
    dc    = c;
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (frames.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("frame_wait_in_budget", frames.size() >= n, 1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       dc;
    logic [7:0] exp_byte;
    int         exp_lat;
    int         exp_low;
    int         exp_rises;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, p, k, acc, cnt;
    frame_t f;

    vecs[0] = '{8'hA5, 1'b0, 8'b1010_0101, 1, 36, 8};
    vecs[1] = '{8'h00, 1'b1, 8'b0000_0000, 1, 36, 8};
    vecs[2] = '{8'hFF, 1'b1, 8'b1111_1111, 1, 36, 8};
    vecs[3] = '{8'hC3, 1'b0, 8'b1100_0011, 1, 36, 8};

    rst   = 1'b1;
    valid = 1'b0;
    data  = '0;
    dc    = 1'b0;
    repeat (3) tick();
    check("rst_cs", o_cs, 1);
    check("rst_sck", o_sck, 1);
    check("rst_mosi", o_mosi, 0);
    check("rst_dc", o_dc, 0);
    check("rst_ready", o_ready, 1);
    check("rst_idle", o_idle, 1);
    rst = 1'b0;
    repeat (2) tick();

    // Single frames: latency, CS low time, bit order, DC, return to idle.
    for (int i = 0; i < 4; i++) begin
      base = frames.size();
      send(vecs[i].data, vecs[i].dc);
      p = cyc;
      wait_frames(base + 1, 200);
      if (frames.size() > base) begin
        f = frames[base];
        check($sformatf("v%0d_byte", i), f.byte_v, vecs[i].exp_byte);
        check($sformatf("v%0d_dc", i), f.dc, vecs[i].dc);
        check($sformatf("v%0d_latency", i), f.fall - p, vecs[i].exp_lat);
        check($sformatf("v%0d_cs_low", i), f.low, vecs[i].exp_low);
        check($sformatf("v%0d_sck_rises", i), f.rises, vecs[i].exp_rises);
        check($sformatf("v%0d_busy_in_gap", i), o_idle, 0);
        while (cyc < f.fall + 39) tick();
        check($sformatf("v%0d_idle_after_39", i), o_idle, 1);
        check($sformatf("v%0d_cs_after", i), o_cs, 1);
      end
    end

    // Command then data byte: DC switches only on the second pop edge.
    base = frames.size();
    send(8'h75, 1'b0);
    send(8'h3F, 1'b1);
    wait_frames(base + 2, 300);
    if (frames.size() >= base + 2) begin
      check("pair_byte0", frames[base].byte_v, 8'b0111_0101);
      check("pair_dc0", frames[base].dc, 0);
      check("pair_byte1", frames[base + 1].byte_v, 8'b0011_1111);
      check("pair_dc1", frames[base + 1].dc, 1);
      check("pair_pitch", frames[base + 1].fall - frames[base].fall, 39);
      check("pair_dc_edge", last_dc_change, frames[base + 1].fall);
    end
    repeat (10) tick();

    // Back-pressure: five accepted, sixth held until the second pop frees a slot.
    base = frames.size();
    for (int i = 1; i <= 5; i++) begin
      data  = 8'(i);
      dc    = 1'b0;
      valid = 1'b1;
      check($sformatf("bp_ready_before_%0d", i), o_ready, 1);
      tick();
    end
    check("bp_full_after_5", o_ready, 0);
    data = 8'h06;
    k    = 0;
    while (!o_ready && k < 200) begin
      tick();
      k++;
    end
    check("bp_ready_returns", k < 200, 1);
    tick();
    acc   = cyc;
    valid = 1'b0;
    wait_frames(base + 6, 600);
    if (frames.size() >= base + 6) begin
      for (int i = 0; i < 6; i++)
        check($sformatf("bp_byte%0d", i), frames[base + i].byte_v, 8'(i + 1));
      for (int i = 1; i < 6; i++)
        check($sformatf("bp_pitch%0d", i), frames[base + i].fall - frames[base + i - 1].fall, PITCH_CYC);
      check("bp_accept_after_pop2", acc, frames[base + 1].fall + 1);
    end
    repeat (10) tick();

    // Reset after the third SCK rise with two entries still queued.
    base = frames.size();
    send(8'hC3, 1'b1);
    send(8'h5A, 1'b0);
    send(8'h81, 1'b0);
    k = 0;
    while (!(in_frame && cur_rises == 3) && k < 200) begin
      tick();
      k++;
    end
    check("rst_mid_reached", k < 200, 1);
    check("rst_mid_dc_before", o_dc, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_cs", o_cs, 1);
    check("rst_mid_sck", o_sck, 1);
    check("rst_mid_mosi", o_mosi, 0);
    check("rst_mid_dc", o_dc, 0);
    check("rst_mid_ready", o_ready, 1);
    check("rst_mid_idle", o_idle, 1);
    repeat (2) tick();
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!o_cs || !o_sck || o_mosi) cnt++;
    end
    check("rst_quiet_100", cnt, 0);
    check("rst_no_frames", frames.size(), base);
    check("rst_post_idle", o_idle, 1);
    check("rst_post_ready", o_ready, 1);

    // Pushes while full are dropped; 0xEE never reaches the bus.
    base = frames.size();
    for (int i = 0; i < 5; i++) send(8'h11 + 8'(i), 1'b1);
    data  = 8'hEE;
    dc    = 1'b1;
    valid = 1'b1;
    cnt   = 0;
    for (int i = 0; i < 10; i++) begin
      if (o_ready) cnt++;
      tick();
    end
    valid = 1'b0;
    check("full_ready_low", cnt, 0);
    wait_frames(base + 5, 600);
    repeat (100) tick();
    check("full_frame_count", frames.size(), base + 5);
    cnt = 0;
    for (int i = base; i < frames.size(); i++)
      if (frames[i].byte_v == 8'hEE) cnt++;
    check("full_no_ee", cnt, 0);
    if (frames.size() >= base + 5)
      for (int i = 0; i < 5; i++)
        check($sformatf("full_byte%0d", i), frames[base + i].byte_v, 8'h11 + 8'(i));

    check("dc_never_mid_frame", dc_bad, 0);
    check("sck_quiet_while_cs_high", idle_sck_bad, 0);
    check("end_idle", o_idle, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
